// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI memory responder: FSM state encodings,
// bus field widths and the read-latency counter preload.
`include "mips_core.svh"

package axi_mem_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE  = 2'd0;
  localparam r_state_t R_WAIT  = 2'd1;
  localparam r_state_t R_BURST = 2'd2;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  // R_WAIT lasts latency-1 cycles and exits when the counter is already zero,
  // so the preload is latency-2 (unused when latency is 1).
  function automatic logic [LEN_W-1:0] lat_load(input int latency);
    if (latency >= 2) begin
      return LEN_W'(latency - 2);
    end
    return '0;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed storage: one synchronous write port and one combinational read
// port. Contents are never reset.
module axi_mem_array
  import axi_mem_pkg::*;
#(
  parameter int WORDS_LOG2 = 14,
  parameter int WIDTH      = DATA_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORDS_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WORDS_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_reg [0:(1 << WORDS_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // A read of the word being written this cycle still sees the old value.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mips_core.svh
// Core-wide bus widths shared by the MIPS core and its memory-side peripherals.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/axi_mem_responder.sv
// AXI-style burst memory slave: independent read and write engines sharing one
// storage array, fixed programmable read latency, sticky write-length error.
`include "mips_core.svh"

module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 14,
  parameter int READ_LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   AWREADY,
  input  logic                   AWVALID,
  input  logic [ID_W-1:0]        AWID,
  input  logic [LEN_W-1:0]       AWLEN,
  input  logic [`ADDR_WIDTH-1:0] AWADDR,
  output logic                   WREADY,
  input  logic                   WVALID,
  input  logic                   WLAST,
  input  logic [ID_W-1:0]        WID,
  input  logic [`DATA_WIDTH-1:0] WDATA,
  input  logic                   BREADY,
  output logic                   BVALID,
  output logic [ID_W-1:0]        BID,
  output logic                   ARREADY,
  input  logic                   ARVALID,
  input  logic [ID_W-1:0]        ARID,
  input  logic [LEN_W-1:0]       ARLEN,
  input  logic [`ADDR_WIDTH-1:0] ARADDR,
  input  logic                   RREADY,
  output logic                   RVALID,
  output logic                   RLAST,
  output logic [ID_W-1:0]        RID,
  output logic [`DATA_WIDTH-1:0] RDATA,
  output logic                   protocol_err
);

  localparam int              IDX_W    = MEM_WORDS_LOG2;
  localparam logic [LEN_W-1:0] LAT_LOAD = lat_load(READ_LATENCY);

  r_state_t          r_state_reg, r_state_next;
  logic [ID_W-1:0]   r_id_reg,    r_id_next;
  logic [LEN_W-1:0]  r_len_reg,   r_len_next;
  logic [LEN_W-1:0]  r_beat_reg,  r_beat_next;
  logic [IDX_W-1:0]  r_idx_reg,   r_idx_next;
  logic [LEN_W-1:0]  r_cnt_reg,   r_cnt_next;

  w_state_t          w_state_reg, w_state_next;
  logic [ID_W-1:0]   w_id_reg,    w_id_next;
  logic [LEN_W-1:0]  w_len_reg,   w_len_next;
  logic [LEN_W-1:0]  w_beat_reg,  w_beat_next;
  logic [IDX_W-1:0]  w_idx_reg,   w_idx_next;
  logic              perr_reg,    perr_next;

  logic ar_fire, r_fire, r_last_beat;
  logic aw_fire, w_fire, w_len_hit, b_fire;
  logic [DATA_W-1:0] mem_rdata;
  logic unused_bits;

  // ---------------- read engine ----------------
  assign ARREADY     = (r_state_reg == R_IDLE);
  assign RVALID      = (r_state_reg == R_BURST);
  assign r_last_beat = (r_beat_reg == r_len_reg);
  assign RLAST       = RVALID && r_last_beat;
  assign RID         = r_id_reg;
  assign RDATA       = mem_rdata;
  assign ar_fire     = ARVALID && ARREADY;
  assign r_fire      = RVALID && RREADY;

  always_comb begin
    r_state_next = r_state_reg;
    r_id_next    = r_id_reg;
    r_len_next   = r_len_reg;
    r_beat_next  = r_beat_reg;
    r_idx_next   = r_idx_reg;
    r_cnt_next   = r_cnt_reg;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_fire) begin
          r_id_next    = ARID;
          r_len_next   = ARLEN;
          r_beat_next  = '0;
          r_idx_next   = ARADDR[IDX_W+1:2];
          r_cnt_next   = LAT_LOAD;
          r_state_next = (READ_LATENCY == 1) ? R_BURST : R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_reg == '0) begin
          r_state_next = R_BURST;
        end else begin
          r_cnt_next = r_cnt_reg - 1'b1;
        end
      end
      R_BURST: begin
        if (r_fire) begin
          if (r_last_beat) begin
            r_state_next = R_IDLE;
          end else begin
            r_beat_next = r_beat_reg + 1'b1;
            r_idx_next  = r_idx_reg + 1'b1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_idx_reg   <= '0;
      r_cnt_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      r_id_reg    <= r_id_next;
      r_len_reg   <= r_len_next;
      r_beat_reg  <= r_beat_next;
      r_idx_reg   <= r_idx_next;
      r_cnt_reg   <= r_cnt_next;
    end
  end

  // ---------------- write engine ----------------
  assign AWREADY      = (w_state_reg == W_IDLE);
  assign WREADY       = (w_state_reg == W_DATA);
  assign BVALID       = (w_state_reg == W_RESP);
  assign BID          = w_id_reg;
  assign protocol_err = perr_reg;
  assign aw_fire      = AWVALID && AWREADY;
  assign w_fire       = WVALID && WREADY;
  assign b_fire       = BVALID && BREADY;
  assign w_len_hit    = (w_beat_reg == w_len_reg);

  always_comb begin
    w_state_next = w_state_reg;
    w_id_next    = w_id_reg;
    w_len_next   = w_len_reg;
    w_beat_next  = w_beat_reg;
    w_idx_next   = w_idx_reg;
    perr_next    = perr_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_fire) begin
          w_id_next    = AWID;
          w_len_next   = AWLEN;
          w_beat_next  = '0;
          w_idx_next   = AWADDR[IDX_W+1:2];
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          // Burst ends on whichever of WLAST or the AWLEN count arrives first.
          if (WLAST || w_len_hit) begin
            w_state_next = W_RESP;
            if (WLAST != w_len_hit) begin
              perr_next = 1'b1;
            end
          end else begin
            w_beat_next = w_beat_reg + 1'b1;
            w_idx_next  = w_idx_reg + 1'b1;
          end
        end
      end
      W_RESP: begin
        if (b_fire) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_len_reg   <= '0;
      w_beat_reg  <= '0;
      w_idx_reg   <= '0;
      perr_reg    <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      w_id_reg    <= w_id_next;
      w_len_reg   <= w_len_next;
      w_beat_reg  <= w_beat_next;
      w_idx_reg   <= w_idx_next;
      perr_reg    <= perr_next;
    end
  end

  // WID and the address bits outside the word index carry no meaning here.
  assign unused_bits = ^{WID, AWADDR, ARADDR};

  axi_mem_array #(
    .WORDS_LOG2 (MEM_WORDS_LOG2),
    .WIDTH      (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (w_fire),
    .waddr (w_idx_reg),
    .wdata (WDATA),
    .raddr (r_idx_reg),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed-plus-random bench for axi_mem_responder against a word-level memory model.
module tb_axi_mem_responder;

  localparam int MW    = 14;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << MW;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AWREADY, AWVALID;
  logic [3:0]  AWID, AWLEN;
  logic [31:0] AWADDR;
  logic        WREADY, WVALID, WLAST;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic        BREADY, BVALID;
  logic [3:0]  BID;
  logic        ARREADY, ARVALID;
  logic [3:0]  ARID, ARLEN;
  logic [31:0] ARADDR;
  logic        RREADY, RVALID, RLAST;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  axi_mem_responder #(
    .MEM_WORDS_LOG2 (MW),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .AWREADY (AWREADY), .AWVALID (AWVALID), .AWID (AWID), .AWLEN (AWLEN), .AWADDR (AWADDR),
    .WREADY (WREADY), .WVALID (WVALID), .WLAST (WLAST), .WID (WID), .WDATA (WDATA),
    .BREADY (BREADY), .BVALID (BVALID), .BID (BID),
    .ARREADY (ARREADY), .ARVALID (ARVALID), .ARID (ARID), .ARLEN (ARLEN), .ARADDR (ARADDR),
    .RREADY (RREADY), .RVALID (RVALID), .RLAST (RLAST), .RID (RID), .RDATA (RDATA),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed=timeout expected=handshake within %0d cycles", tag, TMO);
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'(DEPTH - 1));
  endfunction

  // Writes min(len, wlast_at)+1 beats; data is base+beat when use_base, else random.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int wlast_at, input bit use_base, input logic [31:0] base);
    int nb;
    int idx;
    int t;
    logic [31:0] d;
    nb  = ((wlast_at < len) ? wlast_at : len) + 1;
    idx = widx(addr);
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = 4'(len); AWID = id;
    t = 0;
    while (!AWREADY && t < TMO) begin @(negedge clk); t++; end
    if (!AWREADY) begin timeout("aw_handshake"); AWVALID = 1'b0; return; end
    @(negedge clk);
    AWVALID = 1'b0;
    for (int b = 0; b < nb; b++) begin
      d = use_base ? base + 32'(b) : $urandom;
      WVALID = 1'b1; WDATA = d; WLAST = (b == wlast_at); WID = 4'($urandom);
      t = 0;
      while (!WREADY && t < TMO) begin @(negedge clk); t++; end
      if (!WREADY) begin timeout("w_handshake"); WVALID = 1'b0; return; end
      @(posedge clk);
      model_mem[(idx + b) % DEPTH] = d;
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_after_last_w", 32'(BVALID), 32'd1);
    chk("bid", 32'(BID), 32'(id));
    chk("wready_in_resp", 32'(WREADY), 32'd0);
    @(negedge clk);
    chk("bvalid_cleared", 32'(BVALID), 32'd0);
    $display("write addr=%08h len=%0d id=%0d beats=%0d", addr, len, id, nb);
  endtask

  // Reads len+1 beats, stalling each beat between min_st and max_st cycles.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                         input int min_st, input int max_st);
    int idx;
    int t;
    int lat;
    int s;
    logic [31:0] exp_d;
    idx = widx(addr);
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = 4'(len); ARID = id;
    t = 0;
    while (!ARREADY && t < TMO) begin @(negedge clk); t++; end
    if (!ARREADY) begin timeout("ar_handshake"); ARVALID = 1'b0; return; end
    @(negedge clk);
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < TMO) begin @(negedge clk); lat++; end
    chk("read_latency", 32'(lat), 32'(LAT));
    if (!RVALID) return;
    for (int b = 0; b <= len; b++) begin
      exp_d = model_mem[(idx + b) % DEPTH];
      s = int'($urandom_range(max_st, min_st));
      RREADY = 1'b0;
      for (int k = 0; k < s; k++) begin
        chk("rvalid_stall", 32'(RVALID), 32'd1);
        chk("rdata_stall", RDATA, exp_d);
        chk("rlast_stall", 32'(RLAST), 32'(b == len));
        @(negedge clk);
      end
      RREADY = 1'b1;
      chk("rdata", RDATA, exp_d);
      chk("rid", 32'(RID), 32'(id));
      chk("rlast", 32'(RLAST), 32'(b == len));
      @(negedge clk);
    end
    RREADY = 1'b0;
    chk("rvalid_after_last", 32'(RVALID), 32'd0);
    chk("arready_after_last", 32'(ARREADY), 32'd1);
    $display("read  addr=%08h len=%0d id=%0d", addr, len, id);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] ra;
    logic [31:0] old_d;
    logic [31:0] new_d;
    int len;
    int t;

    rst_n = 1'b0;
    AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
    WVALID = 0; WLAST = 0; WID = 0; WDATA = 0;
    BREADY = 1'b1;
    ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0;
    RREADY = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(AWREADY), 32'd1);
    chk("rst_arready", 32'(ARREADY), 32'd1);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_rid", 32'(RID), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    rst_n = 1'b1;

    // W beats before any AW must not be taken.
    @(negedge clk);
    WVALID = 1'b1; WDATA = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      chk("wready_before_aw", 32'(WREADY), 32'd0);
    end
    WVALID = 1'b0;

    // Basic 4-beat write then read back.
    do_write(32'h100, 3, 4'h5, 3, 1'b1, 32'hA0);
    do_read(32'h100, 3, 4'h9, 0, 0);

    // Single beat with a three-cycle RREADY stall.
    do_write(32'h200, 0, 4'h1, 0, 1'b0, 32'h0);
    do_read(32'h200, 0, 4'hC, 3, 3);

    // Random bursts; read back through aliased addresses (upper/low bits ignored).
    for (int i = 0; i < 6; i++) begin
      a   = $urandom;
      len = int'($urandom_range(15, 0));
      do_write(a, len, 4'($urandom), len, 1'b0, 32'h0);
      ra = (a + 32'(DEPTH * 4) * 32'($urandom_range(3, 1))) ^ 32'($urandom_range(3, 0));
      do_read(ra, len, 4'($urandom), 0, 2);
    end

    // Wrap from the last word to word 0.
    do_write(32'((DEPTH - 1) * 4), 1, 4'h7, 1, 1'b0, 32'h0);
    do_read(32'((DEPTH - 1) * 4), 1, 4'h6, 0, 1);

    // Concurrent disjoint read and write.
    fork
      begin do_write(32'h4000, 3, 4'h3, 3, 1'b0, 32'h0); end
      begin do_read(32'h100, 3, 4'h4, 0, 1); end
    join
    do_read(32'h4000, 3, 4'h2, 0, 0);
    chk("perr_clean", 32'(protocol_err), 32'd0);

    // Same-word collision: R beat accepted in the same cycle as the W beat.
    do_write(32'h800, 0, 4'h1, 0, 1'b0, 32'h0);
    old_d = model_mem[widx(32'h800)];
    new_d = ~old_d;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = 32'h800; ARLEN = 4'd0; ARID = 4'hA;
    t = 0;
    while (!ARREADY && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < TMO) begin @(negedge clk); t++; end
    if (!RVALID) timeout("coll_rvalid");
    AWVALID = 1'b1; AWADDR = 32'h800; AWLEN = 4'd0; AWID = 4'hB;
    t = 0;
    while (!AWREADY && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = new_d; WLAST = 1'b1; RREADY = 1'b1;
    chk("coll_wready", 32'(WREADY), 32'd1);
    chk("coll_old_data", RDATA, old_d);
    chk("coll_rlast", 32'(RLAST), 32'd1);
    @(posedge clk);
    model_mem[widx(32'h800)] = new_d;
    @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
    chk("coll_rvalid_done", 32'(RVALID), 32'd0);
    chk("coll_bvalid", 32'(BVALID), 32'd1);
    chk("coll_bid", 32'(BID), 32'hB);
    @(negedge clk);
    $display("collision addr=00000800 old=%08h new=%08h", old_d, new_d);
    do_read(32'h800, 0, 4'h5, 0, 0);

    // Early WLAST on beat 2 of a 4-beat burst; then a late-WLAST burst.
    do_write(32'h300, 3, 4'hE, 2, 1'b0, 32'h0);
    chk("perr_set", 32'(protocol_err), 32'd1);
    do_write(32'h400, 1, 4'h2, 1, 1'b0, 32'h0);
    chk("perr_sticky", 32'(protocol_err), 32'd1);
    do_write(32'h500, 1, 4'h2, 99, 1'b0, 32'h0);
    chk("perr_still_set", 32'(protocol_err), 32'd1);
    do_read(32'h300, 2, 4'h8, 0, 0);

    // Reset in the middle of a read burst.
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = 32'h100; ARLEN = 4'd3; ARID = 4'hD;
    t = 0;
    while (!ARREADY && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < TMO) begin @(negedge clk); t++; end
    RREADY = 1'b1;
    @(negedge clk);
    chk("mid_burst_rvalid", 32'(RVALID), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(RVALID), 32'd0);
    chk("rst_mid_arready", 32'(ARREADY), 32'd1);
    chk("rst_mid_rid", 32'(RID), 32'd0);
    chk("rst_mid_rlast", 32'(RLAST), 32'd0);
    chk("rst_mid_perr", 32'(protocol_err), 32'd0);
    RREADY = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset during read burst");
    do_read(32'h100, 3, 4'h1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
